// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: D/E/M-stage hazard signals between the pipeline and the hazard unit
interface hazard_forward_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs_d;
  logic [4:0]       rt_d;
  logic             uses_rs_d;
  logic             uses_rt_d;
  logic [4:0]       write_reg_e;
  logic             reg_write_e;
  logic             mem_to_reg_e;
  logic [31:0]      alu_out_e;
  logic             branch_e;
  logic             zero_e;
  logic [1:0]       j_inst_e;
  logic [31:0]      read_data_m;
  logic             forward_src_a_enabled;
  logic [31:0]      forward_src_a;
  logic             forward_src_b_enabled;
  logic [31:0]      forward_src_b;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic             pc_src_e;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output rs_d, rt_d, uses_rs_d, uses_rt_d, write_reg_e, reg_write_e, mem_to_reg_e,
           alu_out_e, branch_e, zero_e, j_inst_e, read_data_m,
    input  forward_src_a_enabled, forward_src_a, forward_src_b_enabled, forward_src_b,
           stall_f, stall_d, flush_d, flush_e, pc_src_e, stall_count, flush_count
  );
  modport slave (
    input  rs_d, rt_d, uses_rs_d, uses_rt_d, write_reg_e, reg_write_e, mem_to_reg_e,
           alu_out_e, branch_e, zero_e, j_inst_e, read_data_m,
    output forward_src_a_enabled, forward_src_a, forward_src_b_enabled, forward_src_b,
           stall_f, stall_d, flush_d, flush_e, pc_src_e, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: E/M/W forwarding, load-use stall, redirect flush and event counters
module hazard_forward_unit #(
  parameter int         CNT_W    = 32,
  parameter logic [4:0] REG_ZERO = 5'd0
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave hz_io
);
  logic [4:0]       write_reg_m_q, write_reg_w_q;
  logic             reg_write_m_q, mem_to_reg_m_q, reg_write_w_q;
  logic [31:0]      alu_out_m_q, result_w_q, result_m;
  logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  logic [33:0]      fa, fb;
  logic             pc_src, lu;
  // {load_hazard, enable, data}; an E-stage load match blocks older M/W matches
  function automatic logic [33:0] fwd(input logic [4:0] r, input logic u);
    if (!u || r == REG_ZERO) return '0;
    if (hz_io.reg_write_e && hz_io.write_reg_e == r)
      return hz_io.mem_to_reg_e ? {2'b10, 32'h0} : {2'b01, hz_io.alu_out_e};
    if (reg_write_m_q && write_reg_m_q == r) return {2'b01, result_m};
    if (reg_write_w_q && write_reg_w_q == r) return {2'b01, result_w_q};
    return '0;
  endfunction
  always_comb begin
    result_m      = mem_to_reg_m_q ? hz_io.read_data_m : alu_out_m_q;
    fa            = fwd(hz_io.rs_d, hz_io.uses_rs_d);
    fb            = fwd(hz_io.rt_d, hz_io.uses_rt_d);
    pc_src        = (hz_io.branch_e && hz_io.zero_e) || (hz_io.j_inst_e != 2'd0);
    lu            = (fa[33] || fb[33]) && !pc_src;
    stall_count_d = (lu && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
    flush_count_d = (pc_src && !(&flush_count_q)) ? flush_count_q + 1'b1 : flush_count_q;
  end
  always_comb begin
    hz_io.forward_src_a_enabled = rst && fa[32];
    hz_io.forward_src_a         = rst ? fa[31:0] : 32'h0;
    hz_io.forward_src_b_enabled = rst && fb[32];
    hz_io.forward_src_b         = rst ? fb[31:0] : 32'h0;
    hz_io.stall_f               = rst && lu;
    hz_io.stall_d               = rst && lu;
    hz_io.flush_d               = rst && pc_src;
    hz_io.flush_e               = rst && (lu || pc_src);
    hz_io.pc_src_e              = rst && pc_src;
    hz_io.stall_count           = rst ? stall_count_q : '0;
    hz_io.flush_count           = rst ? flush_count_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_reg_m_q  <= '0;
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      alu_out_m_q    <= '0;
      write_reg_w_q  <= '0;
      reg_write_w_q  <= 1'b0;
      result_w_q     <= '0;
      stall_count_q  <= '0;
      flush_count_q  <= '0;
    end else begin
      write_reg_m_q  <= hz_io.write_reg_e;
      reg_write_m_q  <= hz_io.reg_write_e;
      mem_to_reg_m_q <= hz_io.mem_to_reg_e;
      alu_out_m_q    <= hz_io.alu_out_e;
      write_reg_w_q  <= write_reg_m_q;
      reg_write_w_q  <= reg_write_m_q;
      result_w_q     <= result_m;
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
    end
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Companion of the Execute stage: produces the forwarding-enable/forward-data pair that Execute samples when the next instruction enters E, plus load-use stall and branch/jump flush controls.
- Shadows the E-stage results through internal M and W pipeline registers, so forwarding sources are tracked locally.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- CNT_W, 32, width of stall and flush event counters (saturating)
- REG_ZERO, 0, architectural zero register index; never forwarded, never stalls

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 resets on the clock edge)
- rs_d  input  5  rs field of instruction in D
- rt_d  input  5  rt field of instruction in D
- uses_rs_d  input  1  D instruction reads rs
- uses_rt_d  input  1  D instruction reads rt
- write_reg_e  input  5  E-stage destination register
- reg_write_e  input  1  E-stage writes register
- mem_to_reg_e  input  1  E-stage instruction is a load
- alu_out_e  input  32  E-stage ALU result
- branch_e  input  1  E-stage is a conditional branch
- zero_e  input  1  E-stage ALU zero flag
- j_inst_e  input  2  E-stage jump kind, nonzero = jump
- read_data_m  input  32  data memory read data for the M-stage instruction
- forward_src_a_enabled  output  1  Execute takes forward_src_a instead of rd1_d
- forward_src_a  output  32  forwarded rs value
- forward_src_b_enabled  output  1  Execute takes forward_src_b instead of rd2_d
- forward_src_b  output  32  forwarded rt value
- stall_f  output  1  hold PC
- stall_d  output  1  hold F/D register
- flush_d  output  1  squash instruction in D
- flush_e  output  1  insert bubble into E (zero control inputs to Execute)
- pc_src_e  output  1  redirect fetch: taken branch or jump in E
- stall_count  output  CNT_W  load-use stall cycles
- flush_count  output  CNT_W  branch/jump redirect events

Behaviour:
- Internal state:
  - M stage: write_reg_m, reg_write_m, mem_to_reg_m, alu_out_m. Captures the E inputs every cycle; the M/W chain never stalls.
  - W stage: write_reg_w, reg_write_w, result_w. result_w captures (mem_to_reg_m ? read_data_m : alu_out_m).
- Reset (rst==0 at an edge): all internal state 0 and both counters 0. While rst==0, every output is forced to 0.
- Forward source for operand A, evaluated combinationally on rs_d; first match wins:
  - No forwarding if uses_rs_d==0 or rs_d==REG_ZERO.
  - E hit: reg_write_e && write_reg_e==rs_d && !mem_to_reg_e → alu_out_e.
  - E load hit (same match, mem_to_reg_e==1) → no forward; load-use hazard.
  - M hit: reg_write_m && write_reg_m==rs_d → (mem_to_reg_m ? read_data_m : alu_out_m).
  - W hit: reg_write_w && write_reg_w==rs_d → result_w.
  - Otherwise forward_src_a_enabled=0 and forward_src_a=0.
- Operand B: identical logic using rt_d and uses_rt_d.
- Effective latency: 0 cycles. Execute registers the selected value on the same edge the D instruction advances.
- pc_src_e = (branch_e && zero_e) || (j_inst_e != 0).
- Load-use: lu = an E load hit on A or B, with pc_src_e==0.
  - lu → stall_f=stall_d=flush_e=1 for exactly one cycle.
  - Next cycle the load is in M and resolves through the M hit path.
- Redirect: pc_src_e → flush_d=flush_e=1 and stall_f=stall_d=0.
- Simultaneous events: redirect overrides load-use, because the stalled instruction is squashed anyway. No stall is counted in that cycle.
- Counters, on each non-reset edge:
  - stall_count += 1 when lu.
  - flush_count += 1 when pc_src_e.
  - Both saturate at all-ones.
- Reset mid-operation: pending M/W writes are discarded. No forwarding from pre-reset instructions after rst returns high.

Test Plan:
- rs_d=3, uses_rs_d=1; E: reg_write_e=1, write_reg_e=3, mem_to_reg_e=0, alu_out_e=0x0000_0010 → forward_src_a_enabled=1, forward_src_a=0x10; no stall.
- Load-use: E load to r4, rt_d=4, uses_rt_d=1 → stall_f=stall_d=flush_e=1 for one cycle, stall_count=1. Next cycle (E bubble, read_data_m=0xDEAD_BEEF) → forward_src_b=0xDEADBEEF, no stall.
- Priority: E writes r5=0x1, M holds r5=0x2, W holds r5=0x3, rs_d=5 → forward_src_a=0x1. Remove the E match → 0x2. Remove the M match → 0x3.
- r0: write_reg_e=0, rs_d=0 → forward_src_a_enabled=0. Same with an E load → no stall.
- Branch_e=1, zero_e=1 with a simultaneous load-use match → pc_src_e=1, flush_d=flush_e=1, stall_f=0, flush_count=1, stall_count unchanged. j_inst_e=2 alone → pc_src_e=1.
- M holds r7 write; drive rst=0 for one edge, then rst=1 with rs_d=7 → forward_src_a_enabled=0; both counters read 0.
